// File: rtl/control_unit_seq_if.sv
// control_unit_seq_if: D-stage control bundle between the control unit (master) and the data path (slave).
interface control_unit_seq_if;
    logic [5:0] op_code;
    logic [5:0] control_unit_funct;
    logic       eq_ne;
    logic       regwrite_d;
    logic       regdst_d;
    logic       alusrc_d;
    logic [3:0] aluctrl_d;
    logic       memwrite_d;
    logic       memtoreg_d;
    logic       se_ze;
    logic [1:0] outselect_d;
    logic       start_mult;
    logic       mult_sign;
    logic       output_branch;
    logic [1:0] pcsrc;
    logic       stall_fd;
    logic       flush_d;
    logic       illegal_instr;
    modport master (
        input  op_code, control_unit_funct, eq_ne,
        output regwrite_d, regdst_d, alusrc_d, aluctrl_d, memwrite_d, memtoreg_d, se_ze,
               outselect_d, start_mult, mult_sign, output_branch, pcsrc, stall_fd, flush_d,
               illegal_instr
    );
    modport slave (
        output op_code, control_unit_funct, eq_ne,
        input  regwrite_d, regdst_d, alusrc_d, aluctrl_d, memwrite_d, memtoreg_d, se_ze,
               outselect_d, start_mult, mult_sign, output_branch, pcsrc, stall_fd, flush_d,
               illegal_instr
    );
endinterface

// File: rtl/control_unit_seq.sv
// control_unit_seq: combinational D-stage decoder with a multiply-busy tracker that
// bubbles HI/LO consumers and back-to-back multiplies until the product is ready.
module control_unit_seq #(
    parameter int MULT_LAT = 4
) (
    input logic                clk,
    input logic                reset,
    control_unit_seq_if.master cu
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        ill_q;
    logic        r_type, add_r, sub_r, and_r, or_r, slt_r, mult_r, multu_r, mfhi_r, mflo_r;
    logic        addi, andi, ori, lw, sw, beq, bne, jmp;
    logic        legal, mul_any, alu_r, hold, take;
    logic [3:0]  aluctrl;
    logic [16:0] dec, bundle;
    assign r_type  = cu.op_code == 6'b000000;
    assign add_r   = r_type && cu.control_unit_funct == 6'b100000;
    assign sub_r   = r_type && cu.control_unit_funct == 6'b100010;
    assign and_r   = r_type && cu.control_unit_funct == 6'b100100;
    assign or_r    = r_type && cu.control_unit_funct == 6'b100101;
    assign slt_r   = r_type && cu.control_unit_funct == 6'b101010;
    assign mult_r  = r_type && cu.control_unit_funct == 6'b011000;
    assign multu_r = r_type && cu.control_unit_funct == 6'b011001;
    assign mfhi_r  = r_type && cu.control_unit_funct == 6'b010000;
    assign mflo_r  = r_type && cu.control_unit_funct == 6'b010010;
    assign addi    = cu.op_code == 6'b001000;
    assign andi    = cu.op_code == 6'b001100;
    assign ori     = cu.op_code == 6'b001101;
    assign lw      = cu.op_code == 6'b100011;
    assign sw      = cu.op_code == 6'b101011;
    assign beq     = cu.op_code == 6'b000100;
    assign bne     = cu.op_code == 6'b000101;
    assign jmp     = cu.op_code == 6'b000010;
    assign alu_r   = add_r | sub_r | and_r | or_r | slt_r;
    assign mul_any = mult_r | multu_r;
    assign legal   = alu_r | mul_any | mfhi_r | mflo_r | addi | andi | ori | lw | sw | beq | bne | jmp;
    assign hold    = state == BUSY && (mul_any || mfhi_r || mflo_r);
    assign take    = (beq && cu.eq_ne) || (bne && !cu.eq_ne);
    assign aluctrl = (sub_r | beq | bne)        ? 4'b0101 :
                     slt_r                      ? 4'b0111 :
                     (or_r | ori)               ? 4'b0001 :
                     (add_r | addi | lw | sw)   ? 4'b0100 : 4'b0000;
    // Undefined encodings fall out as all-zero because no decode term matches.
    assign dec = {
        alu_r | mfhi_r | mflo_r | addi | andi | ori | lw,
        alu_r | mfhi_r | mflo_r,
        addi | andi | ori | lw | sw,
        aluctrl,
        sw,
        lw,
        addi | lw | sw | beq | bne,
        mflo_r, mfhi_r,
        mul_any,
        mult_r,
        bne,
        jmp, take
    };
    assign bundle = (reset && !hold) ? dec : '0;
    assign {cu.regwrite_d, cu.regdst_d, cu.alusrc_d, cu.aluctrl_d, cu.memwrite_d, cu.memtoreg_d,
            cu.se_ze, cu.outselect_d, cu.start_mult, cu.mult_sign, cu.output_branch, cu.pcsrc} = bundle;
    assign cu.stall_fd      = reset && hold;
    assign cu.flush_d       = |bundle[1:0];
    assign cu.illegal_instr = ill_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            ill_q <= 1'b0;
        end else begin
            if (!legal) ill_q <= 1'b1;
            if (state == IDLE) begin
                if (mul_any) begin
                    state <= BUSY;
                    cnt   <= 4'(MULT_LAT);
                end
            end else begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) state <= IDLE;
            end
        end
    end
endmodule
